filter_sequencer: RTL and testbench
===================================

# filter_sequencer

Control sequencer for the FIR audio filter datapath. It accepts one 32-bit stereo sample per frame over the `rts`/`rtr` handshake and writes it into the circular sample buffer. It then steps the MAC through `TAPS` taps (sample and coefficient read addresses, first-tap and accumulate strobes), waits out the MAC pipeline, and holds the output handshake while the barrel-shifter result is consumed downstream. It also owns the barrel-shifter `sel_shift` configuration register and zero-fills the sample buffer after reset.

## Interface
Parameters:
- `TAPS`, 16: number of taps per output sample; range 2..2^`ADDR_W`.
- `ADDR_W`, 4: sample/coefficient buffer address width; buffer depth is 2^`ADDR_W`.
- `MAC_LAT`, 2: cycles from the last tap strobe until the accumulator output is valid; range 1..7.
- `SHIFT_W`, 4: width of `sel_shift`.
- `SHIFT_DEFAULT`, 0: value loaded into `sel_shift` at reset.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `aud_in`  in  32  input sample, {left[31:16], right[15:0]}.
- `aud_in_rts`  in  1  upstream sample valid.
- `aud_in_rtr`  out  1  sequencer ready to accept a sample.
- `wr_en`  out  1  sample buffer write strobe.
- `wr_addr`  out  `ADDR_W`  sample buffer write address.
- `wr_data`  out  32  sample buffer write data.
- `rd_addr`  out  `ADDR_W`  sample buffer read address for the current tap.
- `coef_addr`  out  `ADDR_W`  coefficient ROM address for the current tap.
- `do_multiply_1st`  out  1  first tap: accumulator loads the product.
- `do_multiply`  out  1  tap active: MAC performs multiply-accumulate.
- `sel_shift`  out  `SHIFT_W`  barrel-shifter shift select.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_shift`  in  `SHIFT_W`  new `sel_shift` value.
- `aud_out_rts`  out  1  filtered sample valid downstream.
- `aud_out_rtr`  in  1  downstream ready.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered.
- Reset (`rst`=1 at an edge) forces: state CLEAR, clear counter 0, `wptr` 0, `sel_shift`=`SHIFT_DEFAULT`, pending-config flag 0. All other outputs are 0.
- Reset mid-operation abandons the frame. `aud_out_rts` drops at the next edge, and the CLEAR sequence restarts.
- **CLEAR:**
  - `wr_en`=1, `wr_data`=0, `wr_addr`=0,1,…,2^`ADDR_W`-1 on consecutive cycles.
  - `aud_in_rtr`=0.
  - After the last address, go to IDLE.
- **IDLE:**
  - `aud_in_rtr`=1.
  - On `aud_in_rts`&`aud_in_rtr`: latch `aud_in`, set `newest`=`wptr`, `wptr`=`wptr`+1 mod 2^`ADDR_W`, go to WRITE.
- **WRITE:** one cycle; `wr_en`=1, `wr_addr`=`newest`, `wr_data`=latched sample. Go to MAC with tap counter k=0.
- **MAC:**
  - Runs `TAPS` cycles, k=0..`TAPS`-1.
  - `rd_addr`=(`newest`-k) mod 2^`ADDR_W`; `coef_addr`=k.
  - `do_multiply`=1 every tap; `do_multiply_1st`=1 only when k=0.
  - After k=`TAPS`-1, go to DRAIN.
- **DRAIN:** `MAC_LAT` cycles with both strobes 0, then go to OUT.
- **OUT:**
  - `aud_out_rts`=1 and held until `aud_out_rtr`=1 at an edge.
  - On that edge, drop `aud_out_rts` and go to IDLE.
  - `rtr` already high on entry completes in one cycle.
- **Configuration:**
  - `cfg_wr` in CLEAR or IDLE: `sel_shift` updates at the next edge.
  - `cfg_wr` in any other state: value goes to a pending register (last write wins) and is applied on the cycle of entry to IDLE. `sel_shift` never changes during MAC, DRAIN or OUT.
  - `cfg_wr` coinciding with entry to IDLE: the new value wins.
- **Wrap-around:** `wptr` and `rd_addr` wrap modulo 2^`ADDR_W`. Taps older than the number of written samples read the zeros left by CLEAR.

## Timing
- CLEAR lasts 2^`ADDR_W` cycles after reset release; `aud_in_rtr` first rises the cycle after.
- Accept at edge 0:
  - WRITE is in cycle 1.
  - MAC runs cycles 2..`TAPS`+1.
  - DRAIN runs cycles `TAPS`+2..`TAPS`+`MAC_LAT`+1.
  - `aud_out_rts` is high from cycle `TAPS`+`MAC_LAT`+2.
- Minimum frame period is `TAPS`+`MAC_LAT`+3 cycles, reached when `aud_out_rtr` is held high.
- `aud_in_rtr` is 0 from the cycle after accept until IDLE is re-entered. Samples are never dropped: upstream holds `rts`.

## Test plan
- Reset, `TAPS`=4, `ADDR_W`=2, `MAC_LAT`=2 -> `wr_en`=1 with `wr_data`=0 at addresses 0,1,2,3 on 4 cycles; `aud_in_rtr` rises on cycle 5; `sel_shift`=`SHIFT_DEFAULT`.
- Sample 0x00010002 accepted at edge 0 ->
  - WRITE to addr 0 at cycle 1.
  - `rd_addr` 0,3,2,1 with `coef_addr` 0..3 in cycles 2..5; `do_multiply_1st` only in cycle 2.
  - `aud_out_rts` rises at cycle 8.
- Five back-to-back samples with `aud_out_rtr` tied high -> period 9 cycles; fifth sample writes addr 0 (wrap); its `rd_addr` sequence is 0,3,2,1.
- `aud_out_rtr` held low 10 cycles in OUT -> `aud_out_rts` stays high, `aud_in_rtr` stays 0; release -> IDLE next cycle.
- `cfg_wr` with `cfg_shift`=3 during MAC, then `cfg_shift`=5 during DRAIN -> `sel_shift` unchanged until IDLE entry, then 5.
- `rst` pulsed during MAC tap 2 -> `do_multiply`=0 and `aud_out_rts`=0 next cycle; full CLEAR repeats; `wptr` restarts at 0.

Source files
------------

// File: rtl/filter_sequencer.sv
// Control sequencer for the FIR audio datapath: buffer clear, sample write,
// tap stepping for the MAC, pipeline drain, output handshake and shift config.
module filter_sequencer #(
  parameter int TAPS          = 16,
  parameter int ADDR_W        = 4,
  parameter int MAC_LAT       = 2,
  parameter int SHIFT_W       = 4,
  parameter int SHIFT_DEFAULT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        aud_in,
  input  logic               aud_in_rts,
  output logic               aud_in_rtr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [31:0]        wr_data,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0]  coef_addr,
  output logic               do_multiply_1st,
  output logic               do_multiply,
  output logic [SHIFT_W-1:0] sel_shift,
  input  logic               cfg_wr,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               aud_out_rts,
  input  logic               aud_out_rtr,
  output logic               busy
);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MAC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  TAP_LAST   = ADDR_W'(TAPS - 1);
  localparam logic [2:0]         DRAIN_LAST = 3'(MAC_LAT);
  localparam logic [SHIFT_W-1:0] SHIFT_RST  = SHIFT_W'(SHIFT_DEFAULT);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_s;
  logic [ADDR_W-1:0]   wptr_r, wptr_s;
  logic [ADDR_W-1:0]   newest_r, newest_s;
  logic [ADDR_W-1:0]   tap_r, tap_s;
  logic [2:0]          drain_r, drain_s;
  logic                pend_r, pend_s;
  logic [SHIFT_W-1:0]  pend_val_r, pend_val_s;

  logic                in_rtr_s, wr_en_s, mul1_s, mul_s, out_rts_s, busy_s;
  logic [ADDR_W-1:0]   wr_addr_s, rd_addr_s, coef_addr_s;
  logic [31:0]         wr_data_s;
  logic [SHIFT_W-1:0]  sel_shift_s;

  // Next state and next registered output values; outputs describe the cycle
  // that follows the edge, so e.g. the WRITE strobe is produced on the accept edge.
  always_comb begin
    state_s     = state_r;
    clr_cnt_s   = clr_cnt_r;
    wptr_s      = wptr_r;
    newest_s    = newest_r;
    tap_s       = tap_r;
    drain_s     = drain_r;
    in_rtr_s    = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = ADDR_ZERO;
    wr_data_s   = 32'd0;
    rd_addr_s   = ADDR_ZERO;
    coef_addr_s = ADDR_ZERO;
    mul1_s      = 1'b0;
    mul_s       = 1'b0;
    out_rts_s   = 1'b0;

    case (state_r)
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_cnt_r;
        clr_cnt_s = clr_cnt_r + ADDR_ONE;
        if (clr_cnt_r == ADDR_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (aud_in_rts && aud_in_rtr) begin
          newest_s  = wptr_r;
          wptr_s    = wptr_r + ADDR_ONE;
          tap_s     = ADDR_ZERO;
          wr_en_s   = 1'b1;
          wr_addr_s = wptr_r;
          wr_data_s = aud_in;
          state_s   = ST_WRITE;
        end else begin
          in_rtr_s  = 1'b1;
        end
      end
      // WRITE already emits tap 0; MAC emits the remaining taps.
      ST_WRITE, ST_MAC: begin
        mul_s       = 1'b1;
        mul1_s      = (tap_r == ADDR_ZERO);
        rd_addr_s   = newest_r - tap_r;
        coef_addr_s = tap_r;
        tap_s       = tap_r + ADDR_ONE;
        if ((state_r == ST_MAC) && (tap_r == TAP_LAST)) begin
          drain_s = 3'd0;
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          out_rts_s = 1'b1;
          state_s   = ST_OUT;
        end else begin
          drain_s   = drain_r + 3'd1;
        end
      end
      ST_OUT: begin
        if (aud_out_rtr) begin
          in_rtr_s  = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          out_rts_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_CLEAR;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // Shift configuration: direct in CLEAR/IDLE, deferred to IDLE entry otherwise.
  always_comb begin
    sel_shift_s = sel_shift;
    pend_s      = pend_r;
    pend_val_s  = pend_val_r;
    if ((state_r == ST_CLEAR) || (state_r == ST_IDLE)) begin
      if (cfg_wr) begin
        sel_shift_s = cfg_shift;
      end else begin
        sel_shift_s = sel_shift;
      end
    end else if (state_s == ST_IDLE) begin
      pend_s = 1'b0;
      if (cfg_wr) begin
        sel_shift_s = cfg_shift;
      end else if (pend_r) begin
        sel_shift_s = pend_val_r;
      end else begin
        sel_shift_s = sel_shift;
      end
    end else if (cfg_wr) begin
      pend_s     = 1'b1;
      pend_val_s = cfg_shift;
    end else begin
      pend_s     = pend_r;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_CLEAR;
      clr_cnt_r       <= ADDR_ZERO;
      wptr_r          <= ADDR_ZERO;
      newest_r        <= ADDR_ZERO;
      tap_r           <= ADDR_ZERO;
      drain_r         <= 3'd0;
      pend_r          <= 1'b0;
      pend_val_r      <= {SHIFT_W{1'b0}};
      sel_shift       <= SHIFT_RST;
      aud_in_rtr      <= 1'b0;
      wr_en           <= 1'b0;
      wr_addr         <= ADDR_ZERO;
      wr_data         <= 32'd0;
      rd_addr         <= ADDR_ZERO;
      coef_addr       <= ADDR_ZERO;
      do_multiply_1st <= 1'b0;
      do_multiply     <= 1'b0;
      aud_out_rts     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_r         <= state_s;
      clr_cnt_r       <= clr_cnt_s;
      wptr_r          <= wptr_s;
      newest_r        <= newest_s;
      tap_r           <= tap_s;
      drain_r         <= drain_s;
      pend_r          <= pend_s;
      pend_val_r      <= pend_val_s;
      sel_shift       <= sel_shift_s;
      aud_in_rtr      <= in_rtr_s;
      wr_en           <= wr_en_s;
      wr_addr         <= wr_addr_s;
      wr_data         <= wr_data_s;
      rd_addr         <= rd_addr_s;
      coef_addr       <= coef_addr_s;
      do_multiply_1st <= mul1_s;
      do_multiply     <= mul_s;
      aud_out_rts     <= out_rts_s;
      busy            <= busy_s;
    end
  end

endmodule

// File: tb/tb_filter_sequencer.sv
// Scoreboard bench for filter_sequencer: stimulus pushes expected writes, taps
// and output timing; a negedge monitor pops and compares.
module tb_filter_sequencer;
  localparam int TAPS = 4, ADDR_W = 2, MAC_LAT = 2, SHIFT_W = 4, SHIFT_DEFAULT = 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PERIOD = TAPS + MAC_LAT + 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] aud_in = 32'd0;
  logic aud_in_rts = 1'b0, aud_in_rtr;
  logic wr_en, do_multiply_1st, do_multiply, aud_out_rts, busy;
  logic [ADDR_W-1:0] wr_addr, rd_addr, coef_addr;
  logic [31:0] wr_data;
  logic [SHIFT_W-1:0] sel_shift, cfg_shift = 4'd0;
  logic cfg_wr = 1'b0, aud_out_rtr = 1'b0;

  filter_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT),
                     .SHIFT_W(SHIFT_W), .SHIFT_DEFAULT(SHIFT_DEFAULT)) dut (
    .clk(clk), .rst(rst), .aud_in(aud_in), .aud_in_rts(aud_in_rts), .aud_in_rtr(aud_in_rtr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .coef_addr(coef_addr), .do_multiply_1st(do_multiply_1st), .do_multiply(do_multiply),
    .sel_shift(sel_shift), .cfg_wr(cfg_wr), .cfg_shift(cfg_shift),
    .aud_out_rts(aud_out_rts), .aud_out_rtr(aud_out_rtr), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct { int cyc; int addr; logic [31:0] data; } wr_exp_t;
  typedef struct { int cyc; int rd; int coef; bit first; logic [31:0] data; } tap_exp_t;
  wr_exp_t  wr_q[$];
  tap_exp_t tap_q[$];
  int       rise_q[$];
  logic [31:0] hist[$];
  logic [31:0] mem_model [DEPTH];
  int checks = 0, errors = 0;
  logic [SHIFT_W-1:0] exp_sel = SHIFT_W'(SHIFT_DEFAULT);
  bit rtr_rand = 1'b0;
  logic rtr_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      aud_out_rtr = rtr_rand ? 1'($urandom_range(0, 1)) : rtr_force;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, tap or output
  bit prev_rts = 1'b0, prev_hs = 1'b0, in_frame = 1'b0, acc_pend = 1'b0;
  always @(negedge clk) begin
    wr_exp_t we;
    tap_exp_t te;
    int rc;
    if (rst_q) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_do_multiply", do_multiply, 0);
      check("rst_aud_out_rts", aud_out_rts, 0);
      check("rst_aud_in_rtr", aud_in_rtr, 0);
      check("rst_busy", busy, 0);
      check("rst_sel_shift", sel_shift, SHIFT_DEFAULT);
      in_frame = 1'b0; acc_pend = 1'b0;
    end else begin
      if (acc_pend) in_frame = 1'b1;
      acc_pend = 1'b0;
      if (wr_en) begin
        mem_model[wr_addr] = wr_data;
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          check("wr_cycle", cyc, we.cyc);
          check("wr_addr", wr_addr, we.addr);
          check("wr_data", wr_data, we.data);
        end
      end
      if (do_multiply) begin
        if (tap_q.size() == 0) check("tap_unexpected", 1, 0);
        else begin
          te = tap_q.pop_front();
          check("tap_cycle", cyc, te.cyc);
          check("tap_rd_addr", rd_addr, te.rd);
          check("tap_coef_addr", coef_addr, te.coef);
          check("tap_first", do_multiply_1st, te.first);
          check("tap_data", mem_model[rd_addr], te.data);
        end
      end else if (do_multiply_1st) check("first_without_tap", 1, 0);
      if (aud_out_rts && !prev_rts) begin
        if (rise_q.size() == 0) check("rts_unexpected", 1, 0);
        else begin
          rc = rise_q.pop_front();
          check("rts_rise_cycle", cyc, rc);
        end
      end
      if (prev_rts && !prev_hs) check("rts_hold", aud_out_rts, 1);
      if (prev_hs) begin
        check("rts_drop", aud_out_rts, 0);
        check("idle_rtr", aud_in_rtr, 1);
        in_frame = 1'b0;
      end
      if (in_frame) check("rtr_low_in_frame", aud_in_rtr, 0);
      if (aud_in_rts && aud_in_rtr) acc_pend = 1'b1;
    end
    prev_rts = aud_out_rts && !rst_q;
    prev_hs  = aud_out_rts && aud_out_rtr && !rst_q;
  end

  task automatic to_edge(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    int r;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    wr_q.delete(); tap_q.delete(); rise_q.delete(); hist.delete();
    exp_sel = SHIFT_W'(SHIFT_DEFAULT);
    #1; rst = 1'b0;
    r = cyc;
    for (int i = 0; i < DEPTH; i++) wr_q.push_back('{r + 1 + i, i, 32'd0});
    while (cyc < r + DEPTH) @(negedge clk);
    check("clear_rtr_low", aud_in_rtr, 0);
    @(negedge clk);
    check("clear_rtr_rise", aud_in_rtr, 1);
    check("clear_sel_shift", sel_shift, exp_sel);
  endtask

  // Offer one sample; expectations are derived from the sample index since reset.
  task automatic send(input logic [31:0] d, output int acc);
    int n, guard;
    @(posedge clk); #1;
    aud_in = d; aud_in_rts = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!aud_in_rtr && guard < 200) begin @(negedge clk); guard++; end
    if (!aud_in_rtr) begin
      check("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      acc = cyc + 1;
      n = hist.size();
      hist.push_back(d);
      wr_q.push_back('{acc, n % DEPTH, d});
      for (int k = 0; k < TAPS; k++)
        tap_q.push_back('{acc + 1 + k, ((n - k) % DEPTH + DEPTH) % DEPTH, k, (k == 0),
                         (n - k >= 0) ? hist[n - k] : 32'd0});
      rise_q.push_back(acc + TAPS + MAC_LAT + 1);
    end
    @(posedge clk); #1;
    aud_in_rts = 1'b0; aud_in = $urandom;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!(aud_in_rtr && !aud_out_rts) && guard < 400) begin @(negedge clk); guard++; end
    check("idle_timeout", aud_in_rtr && !aud_out_rts, 1);
  endtask

  task automatic wait_rts_checking_sel();
    int guard = 0;
    @(negedge clk);
    while (!aud_out_rts && guard < 100) begin
      check("sel_frozen", sel_shift, exp_sel);
      @(negedge clk); guard++;
    end
    check("rts_timeout", aud_out_rts, 1);
  endtask

  task automatic cfg_pulse(input logic [SHIFT_W-1:0] v);
    cfg_wr = 1'b1; cfg_shift = v;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    int acc[5];
    int a;
    do_reset(3);

    // Back-to-back frames from reset, first one the reference sample; fifth wraps to 0.
    rtr_force = 1'b1;
    send(32'h0001_0002, acc[0]);
    for (int i = 1; i < 5; i++) send($urandom, acc[i]);
    for (int i = 1; i < 5; i++) check("frame_period", acc[i] - acc[i-1], PERIOD);
    wait_idle();

    // IDLE config applies at the next edge.
    @(posedge clk); #1;
    cfg_pulse(4'd7); exp_sel = 4'd7;
    @(negedge clk);
    check("cfg_idle", sel_shift, 4'd7);

    // Deferred config with 10 cycles of backpressure in OUT.
    rtr_force = 1'b0;
    send($urandom, a);
    to_edge(a + 2); cfg_pulse(4'd3);
    to_edge(a + 5); cfg_pulse(4'd5);
    wait_rts_checking_sel();
    repeat (10) begin
      @(negedge clk);
      check("sel_frozen_out", sel_shift, exp_sel);
    end
    rtr_force = 1'b1;
    wait_idle();
    exp_sel = 4'd5;
    check("cfg_pending_applied", sel_shift, exp_sel);

    // Pending value loses to a write coinciding with IDLE entry.
    send($urandom, a);
    to_edge(a + 2); cfg_pulse(4'd6);
    to_edge(a + TAPS + MAC_LAT + 1);
    cfg_wr = 1'b1; cfg_shift = 4'd9;
    @(negedge clk);
    check("cfg_unchanged_in_out", sel_shift, 4'd5);
    @(posedge clk); #1; cfg_wr = 1'b0;
    @(negedge clk);
    check("cfg_entry_wins", sel_shift, 4'd9);

    // Reset during MAC tap 2, then the buffer restarts at address 0.
    send($urandom, a);
    to_edge(a + 2);
    do_reset(1);
    send(32'hCAFE_0001, a);
    wait_idle();

    // Randomised frames with random gaps and random downstream stalls.
    rtr_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send($urandom, a);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("wr_queue_drained", wr_q.size(), 0);
    check("tap_queue_drained", tap_q.size(), 0);
    check("rts_queue_drained", rise_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
